// File: rtl/msg_pkg.sv
// Shared types for the message assembler: error codes, assembler states, length width.
package msg_pkg;

  localparam int unsigned LEN_W = 16;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_USER = 2'd1,
    ERR_OVF  = 2'd2,
    ERR_KEEP = 2'd3
  } err_code_e;

  typedef enum logic {
    ACCUM   = 1'b0,
    DISCARD = 1'b1
  } asm_state_e;

endpackage

// File: rtl/msg_queue.sv
// Completed-message FIFO; slot 0 is the head and doubles as the output register.
module msg_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH*WIDTH-1:0] mem_q, mem_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n, cnt_pop;
  logic                   pop, push;

  // Pop shifts every slot toward the head; a push lands in the first free slot after that.
  always_comb begin
    pop     = out_valid && out_ready;
    cnt_pop = cnt_q - CNT_W'(pop);
    push    = in_valid && (cnt_pop != CNT_W'(DEPTH));
    mem_n   = pop ? (mem_q >> WIDTH) : mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (cnt_pop == CNT_W'(i))) mem_n[i*WIDTH +: WIDTH] = in_data;
    end
    cnt_n = cnt_pop + CNT_W'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      mem_q     <= mem_n;
      cnt_q     <= cnt_n;
      out_valid <= (cnt_n != '0);
      in_ready  <= (cnt_n != CNT_W'(DEPTH));
    end
  end

  assign out_data = mem_q[WIDTH-1:0];

endmodule

// File: rtl/msg_assembler.sv
// Assembles AXI-ST beats into whole messages with length/error tagging and queues them.
// Optional MSG_ASSEMBLER_STATS_EN adds pop counters stat_msgs/stat_errs.
module msg_assembler
  import msg_pkg::*;
#(
  parameter int unsigned DATA_BYTES    = 8,
  parameter int unsigned MAX_MSG_BYTES = 32,
  parameter int unsigned OUT_DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [8*DATA_BYTES-1:0]    s_tdata,
  input  logic [DATA_BYTES-1:0]      s_tkeep,
  input  logic                       s_tlast,
  input  logic                       s_tuser,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [LEN_W-1:0]           msg_length,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic                       msg_error,
  output logic [1:0]                 msg_err_code
`ifdef MSG_ASSEMBLER_STATS_EN
  ,
  output logic [31:0]                stat_msgs,
  output logic [31:0]                stat_errs
`endif
);

  localparam int unsigned MW = 8 * MAX_MSG_BYTES;
  localparam int unsigned QW = LEN_W + MW + 3;
  localparam int unsigned CW = LEN_W + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_MSG_BYTES);

  asm_state_e            state_q, state_n;
  logic [MW-1:0]         asm_q, asm_wr, asm_n;
  logic [LEN_W-1:0]      cnt_q, cnt_n, len_sat;
  logic                  ovf_q, ovf_n, kerr_q, kerr_n, ovf_b, kerr_b;
  logic                  beat, push, keep_bad, beat_ovf;
  logic [CW-1:0]         kept, sum, off;
  logic [DATA_BYTES-1:0] keep_inc;
  err_code_e             code;
  logic [QW-1:0]         push_data, head;
  logic                  q_ready, q_valid;

  // Beat classification, byte compaction into the buffer, and the payload a tlast would push.
  always_comb begin
    beat = s_tvalid && s_tready;
    kept = '0;
    for (int j = 0; j < DATA_BYTES; j++) kept = kept + CW'(s_tkeep[j]);
    keep_inc = s_tkeep + DATA_BYTES'(1);
    keep_bad = ((keep_inc & s_tkeep) != '0) ||
               (!s_tlast && !(&s_tkeep)) ||
               (s_tlast && (s_tkeep == '0));
    sum      = CW'(cnt_q) + kept;
    beat_ovf = (sum > MAX_C);
    len_sat  = sum[CW-1] ? '1 : sum[LEN_W-1:0];
    ovf_b    = ovf_q || beat_ovf;
    kerr_b   = kerr_q || keep_bad;

    code = ERR_NONE;
    if (ovf_b)        code = ERR_OVF;
    else if (kerr_b)  code = ERR_KEEP;
    else if (s_tuser) code = ERR_USER;

    asm_wr = asm_q;
    off    = CW'(cnt_q);
    if (beat && (state_q == ACCUM)) begin
      for (int j = 0; j < DATA_BYTES; j++) begin
        if (s_tkeep[j]) begin
          for (int k = 0; k < MAX_MSG_BYTES; k++) begin
            if (off == CW'(k)) asm_wr[k*8 +: 8] = s_tdata[j*8 +: 8];
          end
          off = off + CW'(1);
        end
      end
    end
    push_data = {len_sat, asm_wr, (code != ERR_NONE), code};
  end

  // Message framing: a tlast pushes and restarts at offset 0; an oversize non-last beat discards.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ovf_n   = ovf_q;
    kerr_n  = kerr_q;
    asm_n   = asm_wr;
    push    = 1'b0;
    if (beat) begin
      if (s_tlast) begin
        push    = 1'b1;
        state_n = ACCUM;
        cnt_n   = '0;
        ovf_n   = 1'b0;
        kerr_n  = 1'b0;
        asm_n   = '0;
      end else begin
        cnt_n  = len_sat;
        ovf_n  = ovf_b;
        kerr_n = kerr_b;
        if ((state_q == ACCUM) && beat_ovf) state_n = DISCARD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      asm_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      kerr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      asm_q   <= asm_n;
      cnt_q   <= cnt_n;
      ovf_q   <= ovf_n;
      kerr_q  <= kerr_n;
    end
  end

  msg_queue #(
    .WIDTH (QW),
    .DEPTH (OUT_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (push),
    .in_data   (push_data),
    .in_ready  (q_ready),
    .out_valid (q_valid),
    .out_data  (head),
    .out_ready (msg_ready)
  );

  assign s_tready     = q_ready;
  assign msg_valid    = q_valid;
  assign msg_length   = head[QW-1 -: LEN_W];
  assign msg_data     = head[MW+2:3];
  assign msg_error    = head[2];
  assign msg_err_code = head[1:0];

`ifdef MSG_ASSEMBLER_STATS_EN
  // Counted at the consumer side so only delivered messages are reflected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_msgs <= '0;
      stat_errs <= '0;
    end else if (msg_valid && msg_ready) begin
      stat_msgs <= stat_msgs + 32'd1;
      if (msg_error) stat_errs <= stat_errs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msg_assembler.sv
// Self-checking bench for msg_assembler (DATA_BYTES=8, MAX_MSG_BYTES=32, OUT_DEPTH=2).
module tb_msg_assembler;

  localparam int unsigned DB  = 8;
  localparam int unsigned MAX = 32;
  localparam int unsigned DEP = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_tvalid, s_tready, s_tlast, s_tuser;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         msg_valid, msg_ready, msg_error;
  logic [15:0]  msg_length;
  logic [255:0] msg_data;
  logic [1:0]   msg_err_code;
`ifdef MSG_ASSEMBLER_STATS_EN
  logic [31:0]  stat_msgs, stat_errs;
`endif

  int tests = 0;
  int fails = 0;

  msg_assembler #(.DATA_BYTES(DB), .MAX_MSG_BYTES(MAX), .OUT_DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .s_tuser      (s_tuser),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_length   (msg_length),
    .msg_data     (msg_data),
    .msg_error    (msg_error),
`ifdef MSG_ASSEMBLER_STATS_EN
    .stat_msgs    (stat_msgs),
    .stat_errs    (stat_errs),
`endif
    .msg_err_code (msg_err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: messages as byte lists ----------------
  typedef struct {
    logic [15:0]  len;
    logic [255:0] data;
    logic [1:0]   code;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] m_bytes[$];
  int       m_pos = 0;
  bit       m_ovf = 0, m_kerr = 0, live = 0;

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_bytes.delete();
      m_pos = 0; m_ovf = 0; m_kerr = 0; live = 0;
    end else begin
      if (msg_valid && msg_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s_tvalid && s_tready) begin
        bit gap, bad;
        int n;
        exp_t e;
        gap = 0; bad = 0; n = 0;
        for (int j = 0; j < 8; j++) begin
          if (s_tkeep[j]) begin
            if (gap) bad = 1;
            if (m_pos < MAX) m_bytes.push_back(s_tdata[j*8 +: 8]);
            m_pos++; n++;
          end else gap = 1;
        end
        if (!s_tlast && n != 8) bad = 1;
        if (s_tlast && n == 0) bad = 1;
        if (m_pos > MAX) m_ovf = 1;
        if (bad) m_kerr = 1;
        if (s_tlast) begin
          e.len  = (m_pos > 65535) ? 16'hFFFF : 16'(m_pos);
          e.data = '0;
          for (int k = 0; k < 32; k++) if (k < m_bytes.size()) e.data[k*8 +: 8] = m_bytes[k];
          e.code = m_ovf ? 2'd2 : m_kerr ? 2'd3 : s_tuser ? 2'd1 : 2'd0;
          exp_q.push_back(e);
          m_bytes.delete();
          m_pos = 0; m_ovf = 0; m_kerr = 0;
        end
      end
      live = 1;
    end
  end

  // Every cycle: handshake flags and head contents against the model.
  always @(negedge clk) begin
    if (rst && live) begin
      chk("msg_valid", 256'(msg_valid), 256'(exp_q.size() != 0));
      chk("s_tready", 256'(s_tready), 256'(exp_q.size() < DEP));
      if (msg_valid && exp_q.size() != 0) begin
        chk("head_length", 256'(msg_length), 256'(exp_q[0].len));
        chk("head_data", msg_data, exp_q[0].data);
        chk("head_code", 256'(msg_err_code), 256'(exp_q[0].code));
        chk("head_error", 256'(msg_error), 256'(exp_q[0].code != 2'd0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] beat_data(input logic [7:0] base, input int idx);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) d[b*8 +: 8] = base + 8'(8*idx + b);
    return d;
  endfunction

  function automatic logic [255:0] exp_bytes(input logic [7:0] base, input int n);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) if (k < n) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int  guard;
    bit  done;
    guard = 0; done = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
    while (!done) begin
      @(posedge clk);
      if (s_tready) done = 1;
      else if (++guard > 200) begin
        tests++; fails++;
        $display("FAIL beat_timeout: s_tready stuck at %0b", s_tready);
        done = 1;
      end
      #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tkeep = '0; s_tdata = '0;
  endtask

  task automatic send_msg(input logic [7:0] base, input int nb, input logic [7:0] lk, input logic u);
    for (int i = 0; i < nb; i++)
      send_beat(beat_data(base, i), (i == nb - 1) ? lk : 8'hFF, (i == nb - 1), (i == nb - 1) ? u : 1'b0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (msg_valid && g < 100) begin
      @(posedge clk); #1; g++;
    end
    tests++;
    if (msg_valid) begin
      fails++;
      $display("FAIL drain_timeout: msg_valid still %0b", msg_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; msg_ready = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
    #12;
    chk("rst_tready", 256'(s_tready), 256'(0));
    chk("rst_valid", 256'(msg_valid), 256'(0));
    chk("rst_length", 256'(msg_length), 256'(0));
    chk("rst_data", msg_data, 256'(0));
    chk("rst_code", 256'(msg_err_code), 256'(0));
    chk("rst_error", 256'(msg_error), 256'(0));
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_rst", 256'(s_tready), 256'(1));

    // basic 32-byte message, visible the cycle after tlast
    send_msg(8'h10, 4, 8'hFF, 1'b0);
    chk("basic_valid", 256'(msg_valid), 256'(1));
    chk("basic_len", 256'(msg_length), 256'(32));
    chk("basic_code", 256'(msg_err_code), 256'(0));
    chk("basic_byte0", 256'(msg_data[7:0]), 256'(8'h10));
    chk("basic_byte31", 256'(msg_data[255:248]), 256'(8'h2F));
    chk("basic_data", msg_data, exp_bytes(8'h10, 32));
    wait_idle();

    // partial last beat
    send_msg(8'h20, 2, 8'h07, 1'b0);
    chk("partial_len", 256'(msg_length), 256'(11));
    chk("partial_byte10", 256'(msg_data[87:80]), 256'(8'h2A));
    chk("partial_upper_zero", 256'(msg_data[255:88]), 256'(0));
    chk("partial_code", 256'(msg_err_code), 256'(0));
    wait_idle();

    // overflow then clean follow-up
    send_msg(8'h30, 6, 8'hFF, 1'b0);
    chk("ovf_len", 256'(msg_length), 256'(48));
    chk("ovf_code", 256'(msg_err_code), 256'(2));
    chk("ovf_error", 256'(msg_error), 256'(1));
    chk("ovf_data", msg_data, exp_bytes(8'h30, 32));
    wait_idle();
    send_msg(8'h60, 1, 8'hFF, 1'b0);
    chk("post_ovf_len", 256'(msg_length), 256'(8));
    chk("post_ovf_code", 256'(msg_err_code), 256'(0));
    chk("post_ovf_data", msg_data, exp_bytes(8'h60, 8));
    wait_idle();

    // keep error outranks user error
    send_beat(beat_data(8'h40, 0), 8'h0F, 1'b0, 1'b0);
    send_beat(beat_data(8'h40, 1), 8'hFF, 1'b1, 1'b1);
    chk("prio_code", 256'(msg_err_code), 256'(3));
    chk("prio_error", 256'(msg_error), 256'(1));
    chk("prio_len", 256'(msg_length), 256'(12));
    chk("prio_low", 256'(msg_data[39:0]), 256'(40'h48_43424140));
    wait_idle();

    send_msg(8'h70, 1, 8'hFF, 1'b1);
    chk("user_code", 256'(msg_err_code), 256'(1));
    wait_idle();
    send_msg(8'h80, 1, 8'h0B, 1'b0);
    chk("gap_code", 256'(msg_err_code), 256'(3));
    chk("gap_len", 256'(msg_length), 256'(3));
    chk("gap_data", 256'(msg_data[31:0]), 256'(32'h00838180));
    wait_idle();
    send_msg(8'h88, 2, 8'h00, 1'b0);
    chk("zero_keep_code", 256'(msg_err_code), 256'(3));
    chk("zero_keep_len", 256'(msg_length), 256'(8));
    wait_idle();

    // backpressure: two fill the queue, third waits
    msg_ready = 1'b0;
    send_msg(8'h90, 1, 8'hFF, 1'b0);
    send_msg(8'hA8, 1, 8'hFF, 1'b0);
    chk("bp_tready_low", 256'(s_tready), 256'(0));
    chk("bp_head", 256'(msg_data[7:0]), 256'(8'h90));
    fork
      send_msg(8'hB0, 1, 8'hFF, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_held_tready", 256'(s_tready), 256'(0));
        chk("bp_stable_head", 256'(msg_data[7:0]), 256'(8'h90));
        chk("bp_stable_len", 256'(msg_length), 256'(8));
        msg_ready = 1'b1;
      end
    join
    wait_idle();

    // reset mid-message with a queued message outstanding
    msg_ready = 1'b0;
    send_msg(8'hD0, 1, 8'hFF, 1'b0);
    send_beat(beat_data(8'hE0, 0), 8'hFF, 1'b0, 1'b0);
    send_beat(beat_data(8'hE0, 1), 8'hFF, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 256'(msg_valid), 256'(0));
    chk("async_rst_tready", 256'(s_tready), 256'(0));
    chk("async_rst_len", 256'(msg_length), 256'(0));
    chk("async_rst_data", msg_data, 256'(0));
    msg_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    send_msg(8'hC0, 1, 8'hFF, 1'b0);
    chk("after_rst_len", 256'(msg_length), 256'(8));
    chk("after_rst_data", msg_data, exp_bytes(8'hC0, 8));
    chk("after_rst_code", 256'(msg_err_code), 256'(0));
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
